pinball_target_placer: RTL and testbench
========================================

# pinball_target_placer

Controller that places and re-places the six playfield targets (red circle A/B, green circle A/B, purple hexagon A/B). It draws candidate coordinates from a free-running LFSR, rejects out-of-field or overlapping candidates, and falls back to a fixed layout after too many rejections. It also re-places individual targets when the collision logic reports a hit. It sits between the game-state logic (start, hits) and the renderer/collision blocks, which consume the registered coordinates.

## Interface
- NUM_TARGETS, 6, number of targets; index order is red A, red B, green A, green B, purple A, purple B.
- X_MIN / X_MAX, 160 / 480, inclusive x range of a target centre.
- Y_MIN / Y_MAX, 60 / 300, inclusive y range of a target centre.
- MIN_SEP, 40, minimum separation per axis.
- MAX_TRIES, 16, rejections allowed before the fallback position is used.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.
- clk  in  1  system clock. One clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: deactivate all targets and place all of them.
- hit_valid  in  1  one-cycle pulse: target hit_id was hit.
- hit_id  in  3  index of the hit target.
- target_x  out  12*NUM_TARGETS  x coordinate of each target; target i is in bits [12i+11:12i].
- target_y  out  12*NUM_TARGETS  y coordinate of each target, same packing.
- target_active  out  NUM_TARGETS  target is placed and visible.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse when the pending set becomes empty.

## Operation
- LFSR: 16-bit Fibonacci LFSR, shifts left every cycle from reset.
  - feedback = l[15]^l[13]^l[12]^l[10], entering at bit 0.
  - It never pauses, so the player's start timing supplies the entropy.
- pending register, NUM_TARGETS bits:
  - start sets all pending bits and clears all target_active bits.
  - A valid hit sets pending[id] and clears target_active[id].
- Hit filtering: a hit is ignored if hit_id ≥ NUM_TARGETS or target_active[hit_id] = 0.
- The FSM always serves the lowest-index pending target, called cur.
- FSM states:
  - IDLE: go to GEN when pending ≠ 0, selecting cur and clearing tries.
  - GEN: cx = X_MIN + l[8:0] and cy = Y_MIN + l[15:8], using 12-bit arithmetic.
    - If cx > X_MAX or cy > Y_MAX: reject.
    - Otherwise go to CHECK with k = 0.
  - CHECK: each cycle compares the candidate against target k, then increments k.
    - Targets that are inactive, and k = cur, are skipped but still take their cycle.
    - Conflict when |cx−x_k| < MIN_SEP and |cy−y_k| < MIN_SEP; the conflict is a reject.
    - Leave for COMMIT after k = NUM_TARGETS−1.
  - Reject (from GEN or CHECK): tries increments.
    - If tries reaches MAX_TRIES, go to COMMIT with the fallback position.
    - Otherwise return to GEN.
  - COMMIT: write x/y for cur, set target_active[cur], clear pending[cur].
    - If pending is now empty: pulse done and go to IDLE.
    - Otherwise select the next cur and go to GEN.
- Fallback table (x,y): (240,100) (320,100) (400,100) (240,150) (320,150) (400,150).
- start during placement: the current candidate is aborted and the FSM goes to GEN for index 0 on the next cycle.
- start and hit_valid in the same cycle: start wins and the hit is dropped.

## Timing
- Reset values:
  - All target_x and target_y = 0; target_active = 0; pending = 0.
  - busy = 0, done = 0, state IDLE, LFSR = LFSR_SEED.
- All outputs are registered.
- Input response: target_active changes on the cycle after start or hit_valid, and busy rises on the same edge.
- Accepted placement: GEN 1 cycle + CHECK NUM_TARGETS cycles + COMMIT 1 cycle = 8 cycles.
- Each rejection adds 1 cycle (GEN) or up to 7 cycles (CHECK).
- Worst case per target: MAX_TRIES×7 + 1 cycles.
- Output update: coordinates for cur update at the same edge target_active[cur] rises, so they are never visible before activation.
- done is asserted on the cycle the final COMMIT takes effect. busy falls one cycle later.
- A hit arriving during placement is queued in pending and causes no glitch on the other targets.

## Structure
- Package pinball_target_pkg holds:
  - NUM_TARGETS and the coordinate width (12).
  - The fallback x/y table.
  - The FSM state enum (IDLE, GEN, CHECK, COMMIT).
  - The LFSR tap constants.
- One sub-module, pinball_lfsr16, with ports clk, rst, and a 16-bit state output (seed parameter).

## Test plan
- Reset: assert rst for 3 cycles → all coordinates 0, target_active = 0, busy = 0, done = 0.
- start after reset:
  - done pulses once within 6×113 cycles and target_active = 6'b111111.
  - Every x is in 160..480 and every y is in 60..300.
  - No pair has both |dx| < 40 and |dy| < 40.
- Forced fallback, MIN_SEP = 1000 override, then start:
  - Target 0 gets a random position.
  - Targets 1..5 get the fallback table values, e.g. target 1 = (320,100).
  - Each target activates only after 16 rejections.
- Hit after full placement, hit_valid with hit_id = 3:
  - target_active[3] = 0 on the next cycle and busy = 1.
  - Within 113 cycles target 3 is re-placed and done pulses.
  - Targets 0,1,2,4,5 keep identical coordinates throughout.
- Ignored hits: hit_id = 7, and a hit on a target that is still pending → pending, target_active and busy are all unchanged.
- start and hit_valid (id 2) in the same cycle while busy:
  - All targets are deactivated and placement restarts at index 0.
  - Exactly one done pulse follows, with all six targets active.

Source files
------------

// File: rtl/pinball_target_pkg.sv
// Shared constants, FSM state type and lookup helpers for the pinball target placer.
package pinball_target_pkg;
   localparam int unsigned NUM_TARGETS = 6;
   localparam int unsigned COORD_W     = 12;
   localparam int unsigned ID_W        = 3;
   localparam int unsigned LFSR_W      = 16;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;  // bits 15, 13, 12, 10

   typedef enum logic [1:0] {IDLE, GEN, CHECK, COMMIT} state_t;

   function automatic logic [COORD_W-1:0] fallback_x(input logic [ID_W-1:0] idx);
      case (idx)
         3'd0, 3'd3: fallback_x = 12'd240;
         3'd1, 3'd4: fallback_x = 12'd320;
         default:    fallback_x = 12'd400;
      endcase
   endfunction

   function automatic logic [COORD_W-1:0] fallback_y(input logic [ID_W-1:0] idx);
      fallback_y = (idx < 3'd3) ? 12'd100 : 12'd150;
   endfunction

   function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_TARGETS-1:0] v);
      lowest_set = '0;
      for (int i = int'(NUM_TARGETS) - 1; i >= 0; i--) begin
         if (v[i]) lowest_set = ID_W'(i);
      end
   endfunction
endpackage

// File: rtl/pinball_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, shifting left with feedback into bit 0.
module pinball_lfsr16
   import pinball_target_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst,
   output logic [LFSR_W-1:0] state
);
   always_ff @(posedge clk) begin
      if (rst) state <= SEED;
      else     state <= {state[LFSR_W-2:0], ^(state & LFSR_TAPS)};
   end
endmodule

// File: rtl/pinball_target_placer.sv
// Places the six playfield targets from LFSR candidates with bounds and overlap
// rejection, falling back to a fixed layout; re-places individual targets on hits.
module pinball_target_placer
   import pinball_target_pkg::*;
#(
   parameter logic [COORD_W-1:0] X_MIN     = 12'd160,
   parameter logic [COORD_W-1:0] X_MAX     = 12'd480,
   parameter logic [COORD_W-1:0] Y_MIN     = 12'd60,
   parameter logic [COORD_W-1:0] Y_MAX     = 12'd300,
   parameter logic [COORD_W-1:0] MIN_SEP   = 12'd40,
   parameter int unsigned        MAX_TRIES = 16,
   parameter logic [LFSR_W-1:0]  LFSR_SEED = 16'hACE1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           hit_valid,
   input  logic [ID_W-1:0]                hit_id,
   output logic [COORD_W*NUM_TARGETS-1:0] target_x,
   output logic [COORD_W*NUM_TARGETS-1:0] target_y,
   output logic [NUM_TARGETS-1:0]         target_active,
   output logic                           busy,
   output logic                           done
);
   localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
   localparam int unsigned XY_W  = COORD_W * NUM_TARGETS;
   localparam int unsigned IDX_N = 1 << ID_W;

   logic [LFSR_W-1:0]      lfsr;
   state_t                 state, state_n;
   logic [ID_W-1:0]        cur, cur_n, k, k_n;
   logic [TRY_W-1:0]       tries, tries_n;
   logic [COORD_W-1:0]     cx, cx_n, cy, cy_n;
   logic                   use_fb, use_fb_n;
   logic [NUM_TARGETS-1:0] pending, pending_n, active_n;
   logic [XY_W-1:0]        x_n, y_n;
   logic                   done_n, busy_n;

   logic                   hit_ok, reject, conflict;
   logic [IDX_N-1:0]       active_ext;
   logic [NUM_TARGETS-1:0] hit_bit, cur_bit, pend_in, act_base;
   logic [COORD_W-1:0]     xk, yk, dx, dy;

   pinball_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .state (lfsr)
   );

   always_comb begin
      active_ext = IDX_N'(target_active);
      hit_bit    = NUM_TARGETS'(1) << hit_id;
      cur_bit    = NUM_TARGETS'(1) << cur;
      hit_ok     = hit_valid && (32'(hit_id) < NUM_TARGETS) && active_ext[hit_id];
      pend_in    = pending | (hit_ok ? hit_bit : '0);
      act_base   = hit_ok ? (target_active & ~hit_bit) : target_active;

      // Candidate vs. target k, per-axis separation.
      xk       = target_x[COORD_W*32'(k) +: COORD_W];
      yk       = target_y[COORD_W*32'(k) +: COORD_W];
      dx       = (cx >= xk) ? cx - xk : xk - cx;
      dy       = (cy >= yk) ? cy - yk : yk - cy;
      conflict = active_ext[k] && (k != cur) && (dx < MIN_SEP) && (dy < MIN_SEP);

      state_n   = state;
      cur_n     = cur;
      k_n       = k;
      tries_n   = tries;
      cx_n      = cx;
      cy_n      = cy;
      use_fb_n  = use_fb;
      pending_n = pend_in;
      active_n  = act_base;
      x_n       = target_x;
      y_n       = target_y;
      done_n    = 1'b0;
      reject    = 1'b0;

      case (state)
         IDLE: begin
            if (pend_in != '0) begin
               state_n = GEN;
               cur_n   = lowest_set(pend_in);
               tries_n = '0;
            end
         end
         GEN: begin
            cx_n = X_MIN + COORD_W'(lfsr[8:0]);
            cy_n = Y_MIN + COORD_W'(lfsr[15:8]);
            if ((cx_n > X_MAX) || (cy_n > Y_MAX)) begin
               reject = 1'b1;
            end else begin
               state_n = CHECK;
               k_n     = '0;
            end
         end
         CHECK: begin
            if (conflict) begin
               reject = 1'b1;
            end else if (k == ID_W'(NUM_TARGETS - 1)) begin
               state_n  = COMMIT;
               use_fb_n = 1'b0;
            end else begin
               k_n = k + ID_W'(1);
            end
         end
         COMMIT: begin
            x_n[COORD_W*32'(cur) +: COORD_W] = use_fb ? fallback_x(cur) : cx;
            y_n[COORD_W*32'(cur) +: COORD_W] = use_fb ? fallback_y(cur) : cy;
            active_n  = act_base | cur_bit;
            pending_n = pend_in & ~cur_bit;
            if (pending_n == '0) begin
               done_n  = 1'b1;
               state_n = IDLE;
            end else begin
               cur_n   = lowest_set(pending_n);
               tries_n = '0;
               state_n = GEN;
            end
         end
         default: state_n = IDLE;
      endcase

      if (reject) begin
         tries_n = tries + TRY_W'(1);
         if (tries_n == TRY_W'(MAX_TRIES)) begin
            state_n  = COMMIT;
            use_fb_n = 1'b1;
         end else begin
            state_n = GEN;
         end
      end

      // start aborts everything in flight, including a commit in this cycle.
      if (start) begin
         state_n   = GEN;
         cur_n     = '0;
         tries_n   = '0;
         pending_n = '1;
         active_n  = '0;
         x_n       = target_x;
         y_n       = target_y;
         done_n    = 1'b0;
      end

      // busy covers the done cycle so it drops one cycle after the final commit.
      busy_n = (state_n != IDLE) || done_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cur           <= '0;
         k             <= '0;
         tries         <= '0;
         cx            <= '0;
         cy            <= '0;
         use_fb        <= 1'b0;
         pending       <= '0;
         target_active <= '0;
         target_x      <= '0;
         target_y      <= '0;
         done          <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state         <= state_n;
         cur           <= cur_n;
         k             <= k_n;
         tries         <= tries_n;
         cx            <= cx_n;
         cy            <= cy_n;
         use_fb        <= use_fb_n;
         pending       <= pending_n;
         target_active <= active_n;
         target_x      <= x_n;
         target_y      <= y_n;
         done          <= done_n;
         busy          <= busy_n;
      end
   end
endmodule

// File: tb/tb_pinball_target_placer.sv
// Randomized bench for pinball_target_placer: an attempt-level reference model
// predicts every output each cycle for a normal and a forced-fallback instance.
module tb_pinball_target_placer;
   localparam int N = 6;

   logic        clk = 1'b0;
   logic        rst, start, hit_valid;
   logic [2:0]  hit_id;
   logic [71:0] tx0, ty0, tx1, ty1;
   logic [5:0]  ta0, ta1;
   logic        busy0, busy1, done0, done1;

   always #5 clk = ~clk;

   pinball_target_placer u_dut0 (
      .clk(clk), .rst(rst), .start(start), .hit_valid(hit_valid), .hit_id(hit_id),
      .target_x(tx0), .target_y(ty0), .target_active(ta0), .busy(busy0), .done(done0)
   );

   pinball_target_placer #(.MIN_SEP(12'd1000)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .hit_valid(hit_valid), .hit_id(hit_id),
      .target_x(tx1), .target_y(ty1), .target_active(ta1), .busy(busy1), .done(done1)
   );

   int vectors = 0;
   int miscompares = 0;
   bit chk_on = 0;
   int done_cnt[2];

   // Reference model state, one set per instance.
   int mlfsr;
   int mx[2][N], my[2][N];
   int mact[2], mpend[2], mcur[2], mtries[2], mleft[2], mkind[2], mcx[2], mcy[2];
   bit mbusy[2], mdone[2];
   int msep[2] = '{40, 1000};
   int fbx[N] = '{240, 320, 400, 240, 320, 400};
   int fby[N] = '{100, 100, 100, 150, 150, 150};

   function automatic int lfsr_step(int l);
      int fb;
      fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
      return ((l << 1) | fb) & 'hFFFF;
   endfunction

   function automatic int lowest(int v);
      for (int i = 0; i < N; i++) if (((v >> i) & 1) == 1) return i;
      return -1;
   endfunction

   function automatic int iabs(int a);
      return (a < 0) ? -a : a;
   endfunction

   // Decide the whole fate of one candidate up front: how many cycles until it
   // is resolved (kind 0 = rejected, kind 1 = committed with the candidate).
   task automatic begin_attempt(int u);
      int cx, cy;
      cx = 160 + (mlfsr & 511);
      cy = 60 + ((mlfsr >> 8) & 255);
      mcx[u] = cx;
      mcy[u] = cy;
      if (cx > 480 || cy > 300) begin
         mleft[u] = 1; mkind[u] = 0; return;
      end
      for (int j = 0; j < N; j++) begin
         if (((mact[u] >> j) & 1) == 1 && j != mcur[u] &&
             iabs(cx - mx[u][j]) < msep[u] && iabs(cy - my[u][j]) < msep[u]) begin
            mleft[u] = 2 + j; mkind[u] = 0; return;
         end
      end
      mleft[u] = 8; mkind[u] = 1;
   endtask

   task automatic resolve(int u);
      int c;
      if (mkind[u] == 0) begin
         mtries[u]++;
         if (mtries[u] == 16) begin mkind[u] = 2; mleft[u] = 1; end
         else begin_attempt(u);
      end else begin
         c = mcur[u];
         mx[u][c] = (mkind[u] == 2) ? fbx[c] : mcx[u];
         my[u][c] = (mkind[u] == 2) ? fby[c] : mcy[u];
         mact[u] |= (1 << c);
         mpend[u] &= ~(1 << c);
         if (mpend[u] == 0) begin
            mdone[u] = 1; mcur[u] = -1;
         end else begin
            mcur[u] = lowest(mpend[u]); mtries[u] = 0; begin_attempt(u);
         end
      end
   endtask

   task automatic model_step(int u);
      int b;
      if (rst) begin
         for (int i = 0; i < N; i++) begin mx[u][i] = 0; my[u][i] = 0; end
         mact[u] = 0; mpend[u] = 0; mbusy[u] = 0; mdone[u] = 0;
         mcur[u] = -1; mtries[u] = 0; mleft[u] = 0; mkind[u] = 0;
         return;
      end
      mdone[u] = 0;
      if (start) begin
         mact[u] = 0; mpend[u] = 63; mcur[u] = 0; mtries[u] = 0;
         begin_attempt(u);
         mbusy[u] = 1;
         return;
      end
      if (hit_valid && hit_id < 3'd6 && ((mact[u] >> hit_id) & 1) == 1) begin
         b = 1 << hit_id;
         mact[u] &= ~b;
         mpend[u] |= b;
      end
      if (mcur[u] >= 0) begin
         mleft[u]--;
         if (mleft[u] == 0) resolve(u);
      end else if (mpend[u] != 0) begin
         mcur[u] = lowest(mpend[u]); mtries[u] = 0; begin_attempt(u);
      end
      mbusy[u] = (mcur[u] >= 0) || mdone[u];
   endtask

   always @(posedge clk) begin
      mlfsr = rst ? 'hACE1 : lfsr_step(mlfsr);
      for (int u = 0; u < 2; u++) model_step(u);
   end

   function automatic logic [71:0] pack_x(int u);
      logic [71:0] v;
      for (int i = 0; i < N; i++) v[12*i +: 12] = 12'(mx[u][i]);
      return v;
   endfunction

   function automatic logic [71:0] pack_y(int u);
      logic [71:0] v;
      for (int i = 0; i < N; i++) v[12*i +: 12] = 12'(my[u][i]);
      return v;
   endfunction

   function automatic int get12(logic [71:0] v, int i);
      return int'(v[12*i +: 12]);
   endfunction

   task automatic chk(string nm, logic [71:0] a, logic [71:0] e);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s: actual %0h required %0h at %0t", nm, a, e, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("x0", tx0, pack_x(0));
         chk("y0", ty0, pack_y(0));
         chk("act0", 72'(ta0), 72'(mact[0]));
         chk("busy0", 72'(busy0), 72'(mbusy[0]));
         chk("done0", 72'(done0), 72'(mdone[0]));
         chk("x1", tx1, pack_x(1));
         chk("y1", ty1, pack_y(1));
         chk("act1", 72'(ta1), 72'(mact[1]));
         chk("busy1", 72'(busy1), 72'(mbusy[1]));
         chk("done1", 72'(done1), 72'(mdone[1]));
         if (done0) done_cnt[0]++;
         if (done1) done_cnt[1]++;
      end
   end

   task automatic drive(bit s, bit h, int id);
      start = s; hit_valid = h; hit_id = 3'(id);
      @(posedge clk);
      #2;
      start = 0; hit_valid = 0; hit_id = 0;
   endtask

   task automatic wait_idle(int budget, string nm);
      int n = 0;
      while ((busy0 || busy1) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 72'({busy0, busy1}), 72'(0));
   endtask

   task automatic check_ranges(int u, logic [71:0] xs, logic [71:0] ys);
      int bad = 0;
      for (int i = 0; i < N; i++) begin
         if (get12(xs, i) < 160 || get12(xs, i) > 480) bad++;
         if (get12(ys, i) < 60 || get12(ys, i) > 300) bad++;
      end
      chk(u == 0 ? "range0" : "range1", 72'(bad), 72'(0));
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [71:0] keep_x, keep_y, mask;
      int bad, inact, id;
      bit s, h;
      rst = 1; start = 0; hit_valid = 0; hit_id = 0;
      repeat (3) @(posedge clk);
      #2 rst = 0;
      chk_on = 1;
      @(negedge clk);
      chk("rst_x", tx0, 72'(0));
      chk("rst_y", ty0, 72'(0));
      chk("rst_act", 72'(ta0), 72'(0));
      chk("rst_busy_done", 72'({busy0, done0}), 72'(0));

      // Full placement from start.
      done_cnt[0] = 0; done_cnt[1] = 0;
      drive(1, 0, 0);
      chk("start_busy", 72'(busy0), 72'(1));
      wait_idle(6 * 113 + 20, "place_timeout");
      chk("place_done0", 72'(done_cnt[0]), 72'(1));
      chk("place_done1", 72'(done_cnt[1]), 72'(1));
      chk("place_act0", 72'(ta0), 72'(6'h3f));
      chk("place_act1", 72'(ta1), 72'(6'h3f));
      check_ranges(0, tx0, ty0);
      bad = 0;
      for (int i = 0; i < N; i++)
         for (int j = i + 1; j < N; j++)
            if (iabs(get12(tx0, i) - get12(tx0, j)) < 40 &&
                iabs(get12(ty0, i) - get12(ty0, j)) < 40) bad++;
      chk("separation", 72'(bad), 72'(0));
      // Forced-fallback instance: target 0 random in-field, the rest from the table.
      chk("fb_t0_x_range", 72'(get12(tx1, 0) >= 160 && get12(tx1, 0) <= 480), 72'(1));
      for (int i = 1; i < N; i++) begin
         chk("fb_x", 72'(get12(tx1, i)), 72'(fbx[i]));
         chk("fb_y", 72'(get12(ty1, i)), 72'(fby[i]));
      end
      chk("fb_t1_literal", 72'({tx1[23:12], ty1[23:12]}), 72'({12'd320, 12'd100}));

      // Hit on target 3 after full placement.
      keep_x = tx0; keep_y = ty0;
      mask = ~(72'hfff << 36);
      done_cnt[0] = 0;
      drive(0, 1, 3);
      chk("hit_deact", 72'(ta0 & 6'h08), 72'(0));
      chk("hit_busy", 72'(busy0), 72'(1));
      wait_idle(113 + 10, "hit_timeout");
      chk("hit_done", 72'(done_cnt[0]), 72'(1));
      chk("hit_act", 72'(ta0), 72'(6'h3f));
      chk("hit_keep_x", tx0 & mask, keep_x & mask);
      chk("hit_keep_y", ty0 & mask, keep_y & mask);
      chk("hit_fb_t3", 72'({tx1[47:36], ty1[47:36]}), 72'({12'd240, 12'd150}));

      // Ignored hits: out-of-range id, then a still-pending target.
      drive(0, 1, 7);
      chk("ign7_busy", 72'(busy0), 72'(0));
      chk("ign7_act", 72'(ta0), 72'(6'h3f));
      done_cnt[0] = 0;
      drive(1, 0, 0);
      drive(0, 1, 5);
      chk("ign_pend_act", 72'(ta0), 72'(0));
      chk("ign_pend_busy", 72'(busy0), 72'(1));

      // start and hit together while busy.
      drive(1, 1, 2);
      chk("sh_act", 72'(ta0), 72'(0));
      chk("sh_busy", 72'(busy0), 72'(1));
      wait_idle(6 * 113 + 20, "sh_timeout");
      chk("sh_done", 72'(done_cnt[0]), 72'(1));
      chk("sh_act_end", 72'(ta0), 72'(6'h3f));

      // Randomized traffic; valid hits only reach the DUTs while both are idle.
      for (int c = 0; c < 4000; c++) begin
         s = ($urandom_range(0, 299) == 0);
         h = 0; id = 0;
         if (mcur[0] < 0 && mcur[1] < 0) begin
            h = ($urandom_range(0, 3) == 0);
            id = $urandom_range(0, 7);
         end else if ($urandom_range(0, 7) == 0) begin
            inact = ~(mact[0] | mact[1]) & 63;
            id = $urandom_range(0, 7);
            if (id < 6 && ((inact >> id) & 1) == 0) id = 6 + $urandom_range(0, 1);
            h = 1;
         end
         start = s; hit_valid = h; hit_id = 3'(id);
         @(posedge clk);
         #2;
      end
      start = 0; hit_valid = 0; hit_id = 0;
      wait_idle(6 * 113 + 20, "rand_timeout");
      @(negedge clk);
      chk_on = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
